// File: rtl/conv_pkg.sv
// Shared types for the event-driven conv layer: arbiter mode and sequencer phases.
package conv_pkg;

    typedef enum logic [1:0] {
        CONVOLUTION = 2'd0,
        POOLING     = 2'd1,
        PAUSE       = 2'd2
    } arbiter_mode_t;

    typedef enum logic [2:0] {
        SEQ_IDLE       = 3'd0,
        SEQ_CONV_ISSUE = 3'd1,
        SEQ_CONV_WAIT  = 3'd2,
        SEQ_POOL_HOLD  = 3'd3,
        SEQ_POOL_ISSUE = 3'd4,
        SEQ_POOL_WAIT  = 3'd5,
        SEQ_PAUSE      = 3'd6
    } seq_state_t;

    // The feature-map arbiter follows whichever phase the sequencer is in.
    function automatic arbiter_mode_t mode_for_state(input seq_state_t s);
        arbiter_mode_t m;
        case (s)
            SEQ_POOL_HOLD, SEQ_POOL_ISSUE, SEQ_POOL_WAIT: m = POOLING;
            SEQ_PAUSE:                                    m = PAUSE;
            default:                                      m = CONVOLUTION;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_watchdog.sv
// Stall watchdog: counts cycles while 'run' is high and flags when TIMEOUT_CYCLES is reached.
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic w_unused;
            assign w_unused = ^{clk, rst_n, clear, run};
            assign expired  = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            logic [CW-1:0] r_count;

            // Expiry fires on the cycle that completes TIMEOUT_CYCLES of running.
            assign expired = run && (r_count == CW'(TIMEOUT_CYCLES - 1));

            always_ff @(posedge clk) begin
                if (!rst_n || clear) begin
                    r_count <= '0;
                end else if (run && !expired) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/conv_layer_sequencer.sv
// Phase sequencer for one event-driven conv layer: one convolution per spike event,
// a pooling sweep every POOL_EVERY timestep markers, with pause, drop filtering and a watchdog.
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter int BITS_PER_COORDINATE = 8,
    parameter int IN_CHANNELS         = 2,
    parameter int IMG_WIDTH           = 32,
    parameter int IMG_HEIGHT          = 32,
    parameter int POOL_EVERY          = 1,
    parameter int TIMEOUT_CYCLES      = 1024,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           evt_valid,
    output logic                           evt_ready,
    input  logic                           evt_timestep,
    input  logic [BITS_PER_COORDINATE-1:0] evt_x,
    input  logic [BITS_PER_COORDINATE-1:0] evt_y,
    input  logic [IN_CHANNELS-1:0]         evt_spikes,
    output logic                           conv_start,
    output logic [BITS_PER_COORDINATE-1:0] conv_x,
    output logic [BITS_PER_COORDINATE-1:0] conv_y,
    output logic [IN_CHANNELS-1:0]         conv_spikes,
    input  logic                           conv_done,
    output logic                           pool_start,
    input  logic                           pool_done,
    input  logic                           out_full_next,
    output arbiter_mode_t                  arbiter_mode,
    output logic [CNT_WIDTH-1:0]           timestep_count,
    output logic [CNT_WIDTH-1:0]           event_count,
    output logic [CNT_WIDTH-1:0]           drop_count,
    output logic                           busy,
    output logic                           error
);

    localparam int DW = (POOL_EVERY > 1) ? $clog2(POOL_EVERY) : 1;

    seq_state_t                     r_state;
    seq_state_t                     w_next_state;
    arbiter_mode_t                  r_mode;
    logic [BITS_PER_COORDINATE-1:0] r_conv_x;
    logic [BITS_PER_COORDINATE-1:0] r_conv_y;
    logic [IN_CHANNELS-1:0]         r_conv_spikes;
    logic [CNT_WIDTH-1:0]           r_timestep_count;
    logic [CNT_WIDTH-1:0]           r_event_count;
    logic [CNT_WIDTH-1:0]           r_drop_count;
    logic [DW-1:0]                  r_div;
    logic                           r_error;

    logic w_accept;
    logic w_marker;
    logic w_spike;
    logic w_in_range;
    logic w_drop;
    logic w_conv_go;
    logic w_pool_due;
    logic w_run;
    logic w_expired;
    logic w_timeout;
    logic w_wd_clear;

    assign evt_ready  = (r_state == SEQ_IDLE) && enable;
    assign w_accept   = evt_valid && evt_ready;
    assign w_marker   = w_accept && evt_timestep;
    assign w_spike    = w_accept && !evt_timestep;
    assign w_in_range = (32'(evt_x) < 32'(IMG_WIDTH)) && (32'(evt_y) < 32'(IMG_HEIGHT));
    assign w_drop     = w_spike && (!w_in_range || (evt_spikes == '0));
    assign w_conv_go  = w_spike && !w_drop;
    assign w_pool_due = (r_div == DW'(POOL_EVERY - 1));
    assign w_run      = (r_state == SEQ_CONV_WAIT) || (r_state == SEQ_POOL_WAIT);
    assign w_wd_clear = !w_run || (w_next_state != r_state);

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_wd_clear),
        .run    (w_run),
        .expired(w_expired)
    );

    // A done pulse in the same cycle as expiry still counts as a normal completion.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                if (!enable)                     w_next_state = SEQ_PAUSE;
                else if (w_conv_go)              w_next_state = SEQ_CONV_ISSUE;
                else if (w_marker && w_pool_due) w_next_state = SEQ_POOL_HOLD;
            end
            SEQ_CONV_ISSUE: w_next_state = SEQ_CONV_WAIT;
            SEQ_CONV_WAIT: begin
                if (conv_done) begin
                    w_next_state = enable ? SEQ_IDLE : SEQ_PAUSE;
                end else if (w_expired) begin
                    w_next_state = SEQ_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            SEQ_POOL_HOLD: begin
                if (!out_full_next) w_next_state = SEQ_POOL_ISSUE;
            end
            SEQ_POOL_ISSUE: w_next_state = SEQ_POOL_WAIT;
            SEQ_POOL_WAIT: begin
                if (pool_done) begin
                    w_next_state = enable ? SEQ_IDLE : SEQ_PAUSE;
                end else if (w_expired) begin
                    w_next_state = SEQ_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            SEQ_PAUSE: begin
                if (enable) w_next_state = SEQ_IDLE;
            end
            default: w_next_state = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= SEQ_IDLE;
            r_mode           <= CONVOLUTION;
            r_conv_x         <= '0;
            r_conv_y         <= '0;
            r_conv_spikes    <= '0;
            r_timestep_count <= '0;
            r_event_count    <= '0;
            r_drop_count     <= '0;
            r_div            <= '0;
            r_error          <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_mode  <= mode_for_state(w_next_state);
            if (w_conv_go) begin
                r_conv_x      <= evt_x;
                r_conv_y      <= evt_y;
                r_conv_spikes <= evt_spikes;
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
            if (w_marker) begin
                r_timestep_count <= r_timestep_count + 1'b1;
                r_event_count    <= '0;
                r_div            <= w_pool_due ? '0 : r_div + 1'b1;
            end else if ((r_state == SEQ_CONV_WAIT) && conv_done && (r_event_count != '1)) begin
                r_event_count <= r_event_count + 1'b1;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign conv_start     = (r_state == SEQ_CONV_ISSUE);
    assign pool_start     = (r_state == SEQ_POOL_ISSUE);
    assign busy           = (r_state != SEQ_IDLE) && (r_state != SEQ_PAUSE);
    assign conv_x         = r_conv_x;
    assign conv_y         = r_conv_y;
    assign conv_spikes    = r_conv_spikes;
    assign arbiter_mode   = r_mode;
    assign timestep_count = r_timestep_count;
    assign event_count    = r_event_count;
    assign drop_count     = r_drop_count;
    assign error          = r_error;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench for conv_layer_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the sequencer rules.
module tb_conv_layer_sequencer;
    import conv_pkg::*;

    localparam int BPC    = 8;
    localparam int INCH   = 2;
    localparam int IMGW   = 32;
    localparam int IMGH   = 32;
    localparam int POOLN  = 2;
    localparam int TMO    = 16;
    localparam int CW     = 4;
    localparam int SATMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rstN;
    logic            enable;
    logic            evtValid;
    logic            evtReady;
    logic            evtTimestep;
    logic [BPC-1:0]  evtX;
    logic [BPC-1:0]  evtY;
    logic [INCH-1:0] evtSpikes;
    logic            convStart;
    logic [BPC-1:0]  convX;
    logic [BPC-1:0]  convY;
    logic [INCH-1:0] convSpikes;
    logic            convDone;
    logic            poolStart;
    logic            poolDone;
    logic            outFullNext;
    arbiter_mode_t   arbiterMode;
    logic [CW-1:0]   timestepCount;
    logic [CW-1:0]   eventCount;
    logic [CW-1:0]   dropCount;
    logic            busy;
    logic            error;

    always #5 clk = ~clk;

    conv_layer_sequencer #(
        .BITS_PER_COORDINATE(BPC),
        .IN_CHANNELS        (INCH),
        .IMG_WIDTH          (IMGW),
        .IMG_HEIGHT         (IMGH),
        .POOL_EVERY         (POOLN),
        .TIMEOUT_CYCLES     (TMO),
        .CNT_WIDTH          (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rstN),
        .enable        (enable),
        .evt_valid     (evtValid),
        .evt_ready     (evtReady),
        .evt_timestep  (evtTimestep),
        .evt_x         (evtX),
        .evt_y         (evtY),
        .evt_spikes    (evtSpikes),
        .conv_start    (convStart),
        .conv_x        (convX),
        .conv_y        (convY),
        .conv_spikes   (convSpikes),
        .conv_done     (convDone),
        .pool_start    (poolStart),
        .pool_done     (poolDone),
        .out_full_next (outFullNext),
        .arbiter_mode  (arbiterMode),
        .timestep_count(timestepCount),
        .event_count   (eventCount),
        .drop_count    (dropCount),
        .busy          (busy),
        .error         (error)
    );

    int checks   = 0;
    int failures = 0;

    // Model phases describe what the layer is doing, in the order an operation walks through them.
    localparam int P_IDLE   = 0;
    localparam int P_CISSUE = 1;
    localparam int P_CWAIT  = 2;
    localparam int P_PHOLD  = 3;
    localparam int P_PISSUE = 4;
    localparam int P_PWAIT  = 5;
    localparam int P_PAUSE  = 6;

    int mPhase   = P_IDLE;
    int mWait    = 0;
    int mMarkers = 0;
    int mTs      = 0;
    int mEv      = 0;
    int mDrop    = 0;
    int mCx      = 0;
    int mCy      = 0;
    int mSp      = 0;
    bit mErr     = 1'b0;
    bit mArmed   = 1'b0;

    // The model applies the sequencer rules once per rising edge using the inputs seen at that edge.
    always @(posedge clk) begin
        if (!rstN) begin
            mPhase   = P_IDLE;
            mWait    = 0;
            mMarkers = 0;
            mTs      = 0;
            mEv      = 0;
            mDrop    = 0;
            mErr     = 1'b0;
            mArmed   = 1'b1;
        end else if (mArmed) begin
            case (mPhase)
                P_IDLE: begin
                    if (!enable) begin
                        mPhase = P_PAUSE;
                    end else if (evtValid) begin
                        if (evtTimestep) begin
                            mTs      = (mTs + 1) % (SATMAX + 1);
                            mEv      = 0;
                            mMarkers = mMarkers + 1;
                            if (mMarkers % POOLN == 0) mPhase = P_PHOLD;
                        end else if (int'(evtX) >= IMGW || int'(evtY) >= IMGH || evtSpikes == 0) begin
                            if (mDrop < SATMAX) mDrop = mDrop + 1;
                        end else begin
                            mCx    = int'(evtX);
                            mCy    = int'(evtY);
                            mSp    = int'(evtSpikes);
                            mPhase = P_CISSUE;
                        end
                    end
                end
                P_CISSUE: begin
                    mPhase = P_CWAIT;
                    mWait  = 0;
                end
                P_CWAIT: begin
                    if (convDone) begin
                        if (mEv < SATMAX) mEv = mEv + 1;
                        mPhase = enable ? P_IDLE : P_PAUSE;
                    end else begin
                        mWait = mWait + 1;
                        if (mWait == TMO) begin
                            mErr   = 1'b1;
                            mPhase = P_IDLE;
                        end
                    end
                end
                P_PHOLD: begin
                    if (!outFullNext) mPhase = P_PISSUE;
                end
                P_PISSUE: begin
                    mPhase = P_PWAIT;
                    mWait  = 0;
                end
                P_PWAIT: begin
                    if (poolDone) begin
                        mPhase = enable ? P_IDLE : P_PAUSE;
                    end else begin
                        mWait = mWait + 1;
                        if (mWait == TMO) begin
                            mErr   = 1'b1;
                            mPhase = P_IDLE;
                        end
                    end
                end
                default: begin
                    if (enable) mPhase = P_IDLE;
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic arbiter_mode_t modelMode();
        if (mPhase == P_PHOLD || mPhase == P_PISSUE || mPhase == P_PWAIT) return POOLING;
        if (mPhase == P_PAUSE) return PAUSE;
        return CONVOLUTION;
    endfunction

    task automatic compareAll();
        if (!mArmed) return;
        checkOutput("model.evt_ready",  32'(evtReady),      32'(mPhase == P_IDLE && enable));
        checkOutput("model.conv_start", 32'(convStart),     32'(mPhase == P_CISSUE));
        checkOutput("model.pool_start", 32'(poolStart),     32'(mPhase == P_PISSUE));
        checkOutput("model.busy",       32'(busy),          32'(mPhase != P_IDLE && mPhase != P_PAUSE));
        checkOutput("model.arb_mode",   32'(arbiterMode),   32'(modelMode()));
        checkOutput("model.timesteps",  32'(timestepCount), 32'(mTs));
        checkOutput("model.events",     32'(eventCount),    32'(mEv));
        checkOutput("model.drops",      32'(dropCount),     32'(mDrop));
        checkOutput("model.error",      32'(error),         32'(mErr));
        if (mPhase == P_CISSUE || mPhase == P_CWAIT) begin
            checkOutput("model.conv_x",      32'(convX),      32'(mCx));
            checkOutput("model.conv_y",      32'(convY),      32'(mCy));
            checkOutput("model.conv_spikes", 32'(convSpikes), 32'(mSp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendEvent(input bit ts, input int x, input int y, input int sp);
        evtValid    = 1'b1;
        evtTimestep = ts;
        evtX        = BPC'(x);
        evtY        = BPC'(y);
        evtSpikes   = INCH'(sp);
        step();
        evtValid    = 1'b0;
        evtTimestep = 1'b0;
    endtask

    int starveLeft = 0;

    task automatic applyStimulus();
        evtValid    = ($urandom_range(0, 1) == 1);
        evtTimestep = ($urandom_range(0, 5) == 0);
        evtX        = BPC'($urandom_range(0, 40));
        evtY        = BPC'($urandom_range(0, 40));
        evtSpikes   = INCH'($urandom_range(0, 3));
        enable      = ($urandom_range(0, 15) != 0);
        outFullNext = ($urandom_range(0, 2) == 0);
        rstN        = ($urandom_range(0, 499) != 0);
        if (starveLeft > 0) begin
            starveLeft--;
            convDone = 1'b0;
            poolDone = 1'b0;
        end else begin
            if ($urandom_range(0, 199) == 0) starveLeft = 40;
            convDone = ($urandom_range(0, 4) == 0);
            poolDone = ($urandom_range(0, 4) == 0);
        end
    endtask

    task automatic runScenarios();
        // Reset state
        repeat (3) step();
        @(negedge clk);
        checkOutput("reset.conv_start", 32'(convStart),     32'd0);
        checkOutput("reset.arb_mode",   32'(arbiterMode),   32'(CONVOLUTION));
        checkOutput("reset.counters",   32'({timestepCount, eventCount, dropCount}), 32'd0);
        checkOutput("reset.busy_err",   32'({busy, error}), 32'd0);
        rstN   = 1'b1;
        enable = 1'b1;
        step();

        // Accepted event issues a convolution one cycle later
        evtValid = 1'b1; evtX = 8'd3; evtY = 8'd4; evtSpikes = 2'b01;
        @(negedge clk);
        checkOutput("t1.evt_ready", 32'(evtReady), 32'd1);
        step();
        evtValid = 1'b0;
        @(negedge clk);
        checkOutput("t1.conv_start", 32'(convStart), 32'd1);
        checkOutput("t1.conv_x",     32'(convX),     32'd3);
        checkOutput("t1.conv_y",     32'(convY),     32'd4);
        step();
        @(negedge clk);
        checkOutput("t1.start_pulse", 32'(convStart), 32'd0);
        convDone = 1'b1; step(); convDone = 1'b0;
        @(negedge clk);
        checkOutput("t1.event_count", 32'(eventCount), 32'd1);

        // Out-of-range and silent events are dropped
        sendEvent(1'b0, 32, 0, 1);
        sendEvent(1'b0, 5, 5, 0);
        @(negedge clk);
        checkOutput("t2.drop_count", 32'(dropCount), 32'd2);
        checkOutput("t2.evt_ready",  32'(evtReady),  32'd1);

        // Pooling only on every second marker
        sendEvent(1'b1, 0, 0, 0);
        @(negedge clk);
        checkOutput("t3.no_pool",  32'(arbiterMode),   32'(CONVOLUTION));
        checkOutput("t3.ev_clear", 32'(eventCount),    32'd0);
        sendEvent(1'b1, 0, 0, 0);
        @(negedge clk);
        checkOutput("t3.pooling",   32'(arbiterMode),   32'(POOLING));
        checkOutput("t3.timesteps", 32'(timestepCount), 32'd2);
        step();
        @(negedge clk);
        checkOutput("t3.pool_start", 32'(poolStart), 32'd1);
        step();
        @(negedge clk);
        checkOutput("t3.pool_wait", 32'(arbiterMode), 32'(POOLING));
        poolDone = 1'b1; step(); poolDone = 1'b0;
        @(negedge clk);
        checkOutput("t3.back_conv", 32'(arbiterMode), 32'(CONVOLUTION));

        // Output FIFO back-pressure holds the pool sweep
        outFullNext = 1'b1;
        sendEvent(1'b1, 0, 0, 0);
        sendEvent(1'b1, 0, 0, 0);
        repeat (4) begin
            step();
            @(negedge clk);
            checkOutput("t4.held", 32'(poolStart), 32'd0);
        end
        outFullNext = 1'b0;
        step();
        @(negedge clk);
        checkOutput("t4.pool_start", 32'(poolStart),     32'd1);
        checkOutput("t4.timesteps",  32'(timestepCount), 32'd4);
        step();
        poolDone = 1'b1; step(); poolDone = 1'b0;

        // Pause waits for the in-flight convolution
        sendEvent(1'b0, 10, 10, 2);
        step();
        enable = 1'b0;
        repeat (3) begin
            step();
            @(negedge clk);
            checkOutput("t5.still_busy", 32'(busy), 32'd1);
        end
        convDone = 1'b1; step(); convDone = 1'b0;
        @(negedge clk);
        checkOutput("t5.paused",   32'(arbiterMode), 32'(PAUSE));
        checkOutput("t5.no_ready", 32'(evtReady),    32'd0);
        enable = 1'b1;
        step();
        @(negedge clk);
        checkOutput("t5.resumed", 32'(evtReady), 32'd1);

        // Watchdog expiry and mid-op reset
        sendEvent(1'b0, 1, 1, 1);
        step();
        repeat (15) step();
        @(negedge clk);
        checkOutput("t6.before_expiry", 32'(error), 32'd0);
        step();
        @(negedge clk);
        checkOutput("t6.error", 32'(error), 32'd1);
        checkOutput("t6.idle",  32'(busy),  32'd0);
        convDone = 1'b1; step(); convDone = 1'b0;
        @(negedge clk);
        checkOutput("t6.late_done", 32'(eventCount), 32'd1);
        sendEvent(1'b0, 2, 2, 1);
        step();
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("t6.reset_err",   32'(error), 32'd0);
        checkOutput("t6.reset_count", 32'({timestepCount, eventCount, dropCount}), 32'd0);
        step();
        @(negedge clk);
        checkOutput("t6.no_start", 32'(convStart), 32'd0);

        // Drop counter saturates
        repeat (SATMAX + 3) sendEvent(1'b0, 0, 0, 0);
        @(negedge clk);
        checkOutput("sat.drop_count", 32'(dropCount), 32'(SATMAX));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            step();
        end
        rstN = 1'b1; evtValid = 1'b0; convDone = 1'b0; poolDone = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        rstN = 1'b0; enable = 1'b0; evtValid = 1'b0; evtTimestep = 1'b0;
        evtX = '0; evtY = '0; evtSpikes = '0;
        convDone = 1'b0; poolDone = 1'b0; outFullNext = 1'b0;
        fork
            runScenarios();
            forever begin
                @(negedge clk);
                compareAll();
            end
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
